microseq_ctrl: RTL and testbench

//   Parametrised microcode sequencer for the 8-bit bus CPU. Owns the micro-step

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/microseq_decode.sv | 71 +++++++
 rtl/microseq_ctrl.sv | 95 +++++++++
 tb/tb_microseq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the microcode sequencer: control-word bit indices,
// opcode encodings and flag bit positions.
package ctrl_pkg;

    localparam int CW_W = 16;

    localparam int CW_HT = 15;
    localparam int CW_MI = 14;
    localparam int CW_RI = 13;
    localparam int CW_RO = 12;
    localparam int CW_IO = 11;
    localparam int CW_II = 10;
    localparam int CW_AI = 9;
    localparam int CW_AO = 8;
    localparam int CW_EO = 7;
    localparam int CW_SU = 6;
    localparam int CW_BI = 5;
    localparam int CW_OI = 4;
    localparam int CW_CE = 3;
    localparam int CW_CO = 2;
    localparam int CW_JP = 1;
    localparam int CW_FI = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    function automatic logic [CW_W-1:0] cw_bit(input int idx);
        logic [CW_W-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/microseq_decode.sv
// Combinational microcode table: (opcode, step, flags) -> control word and
// last-step marker. Steps 0/1 are the shared fetch for every opcode.
module microseq_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int STEP_W   = 3,
    parameter int MAX_STEP = 4,
    parameter int FLAG_W   = 2
) (
    input  logic [OP_W-1:0]   opcode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic [CW_W-1:0]   cw_o,
    output logic              last_o
);

    logic [3:0] op4;
    int         s;
    int         last_int;

    always_comb begin
        op4      = 4'(opcode_i);
        s        = int'(step_i);
        cw_o     = '0;
        last_int = 2;
        if (s == 0) begin
            cw_o = cw_bit(CW_CO) | cw_bit(CW_MI);
        end else if (s == 1) begin
            cw_o = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
        end else begin
            case (op4)
                OP_LDA: begin
                    last_int = 3;
                    if (s == 2)      cw_o = cw_bit(CW_IO) | cw_bit(CW_MI);
                    else if (s == 3) cw_o = cw_bit(CW_RO) | cw_bit(CW_AI);
                end
                OP_ADD, OP_SUB: begin
                    last_int = 4;
                    if (s == 2)      cw_o = cw_bit(CW_IO) | cw_bit(CW_MI);
                    else if (s == 3) cw_o = cw_bit(CW_RO) | cw_bit(CW_BI);
                    else if (s == 4) begin
                        cw_o = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                        if (op4 == OP_SUB) cw_o = cw_o | cw_bit(CW_SU);
                    end
                end
                OP_STA: begin
                    last_int = 3;
                    if (s == 2)      cw_o = cw_bit(CW_IO) | cw_bit(CW_MI);
                    else if (s == 3) cw_o = cw_bit(CW_AO) | cw_bit(CW_RI);
                end
                OP_LDI: if (s == 2) cw_o = cw_bit(CW_IO) | cw_bit(CW_AI);
                OP_JMP: if (s == 2) cw_o = cw_bit(CW_IO) | cw_bit(CW_JP);
                OP_JC: if (s == 2) begin
                    cw_o = cw_bit(CW_IO);
                    if (flags_i[FLAG_C]) cw_o = cw_o | cw_bit(CW_JP);
                end
                OP_JZ: if (s == 2) begin
                    cw_o = cw_bit(CW_IO);
                    if (flags_i[FLAG_Z]) cw_o = cw_o | cw_bit(CW_JP);
                end
                OP_OUT: if (s == 2) cw_o = cw_bit(CW_AO) | cw_bit(CW_OI);
                OP_HLT: if (s == 2) cw_o = cw_bit(CW_HT);
                default: cw_o = '0;
            endcase
        end
        // Clamp at MAX_STEP so the counter can never run past the table.
        last_o = (s >= last_int) || (s >= MAX_STEP);
    end

endmodule

// File: rtl/microseq_ctrl.sv
// Microcode sequencer top: step counter, halt latch and registered outputs,
// all updated on the falling edge. Optional single-step: CTRL_SINGLE_STEP_EN.
module microseq_ctrl
    import ctrl_pkg::*;
#(
    parameter int IR_W     = 8,
    parameter int OP_W     = 4,
    parameter int STEP_W   = 3,
    parameter int MAX_STEP = 4,
    parameter int FLAG_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IR_W-1:0]   ir,
    input  logic [FLAG_W-1:0] flags,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
`endif
    output logic [CW_W-1:0]   ctrl_word,
    output logic [STEP_W-1:0] step,
    output logic              instr_done,
    output logic              halted
);

    logic [CW_W-1:0]   cw_q, cw_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              done_q, done_d;
    logic              halted_q, halted_d;
    logic [CW_W-1:0]   dec_cw;
    logic              dec_last;
    logic              advance;

    // cnt_q is the step to be emitted next; step_q is the step currently shown.
    microseq_decode #(
        .OP_W     (OP_W),
        .STEP_W   (STEP_W),
        .MAX_STEP (MAX_STEP),
        .FLAG_W   (FLAG_W)
    ) u_decode (
        .opcode_i (ir[IR_W-1 -: OP_W]),
        .step_i   (cnt_q),
        .flags_i  (flags),
        .cw_o     (dec_cw),
        .last_o   (dec_last)
    );

`ifdef CTRL_SINGLE_STEP_EN
    assign advance = !step_mode || step_req;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        cnt_d    = cnt_q;
        step_d   = step_q;
        cw_d     = '0;
        done_d   = done_q;
        halted_d = halted_q;
        if (halted_q) begin
            cw_d = '0;
        end else if (!advance) begin
            done_d = 1'b0;
        end else begin
            cw_d     = dec_cw;
            step_d   = cnt_q;
            done_d   = dec_last;
            cnt_d    = dec_last ? '0 : cnt_q + STEP_W'(1);
            halted_d = dec_cw[CW_HT];
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            cw_q     <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            cw_q     <= cw_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            done_q   <= done_d;
            halted_q <= halted_d;
        end
    end

    assign ctrl_word  = cw_q;
    assign step       = step_q;
    assign instr_done = done_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl: fetch/execute tables, flag-dependent jumps,
// halt freeze, mid-instruction reset and (with CTRL_SINGLE_STEP_EN) single-step.
module tb_microseq_ctrl;
    import ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ir;
    logic [1:0]  flags;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        instr_done;
    logic        halted;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step_mode;
    logic        step_req;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [15:0] W_F0   = 16'h0004 | 16'h4000;           // CO|MI
    localparam logic [15:0] W_F1   = 16'h1000 | 16'h0400 | 16'h0008; // RO|II|CE
    localparam logic [15:0] W_IOMI = 16'h0800 | 16'h4000;
    localparam logic [15:0] W_ROAI = 16'h1000 | 16'h0200;
    localparam logic [15:0] W_ROBI = 16'h1000 | 16'h0020;
    localparam logic [15:0] W_ADD4 = 16'h0080 | 16'h0200 | 16'h0001; // EO|AI|FI
    localparam logic [15:0] W_SUB4 = W_ADD4 | 16'h0040;
    localparam logic [15:0] W_AORI = 16'h0100 | 16'h2000;
    localparam logic [15:0] W_IOAI = 16'h0800 | 16'h0200;
    localparam logic [15:0] W_IOJP = 16'h0800 | 16'h0002;
    localparam logic [15:0] W_IO   = 16'h0800;
    localparam logic [15:0] W_AOOI = 16'h0100 | 16'h0010;
    localparam logic [15:0] W_HT   = 16'h8000;

    microseq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ir         (ir),
        .flags      (flags),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step_req   (step_req),
`endif
        .ctrl_word  (ctrl_word),
        .step       (step),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One falling edge, then compare all four outputs.
    task automatic cyc(input string tag, input logic [15:0] ecw, input int est,
                       input logic edone, input logic ehalt);
        @(negedge clk);
        #1;
        check({tag, "_cw"},   32'(ctrl_word),  32'(ecw));
        check({tag, "_step"}, 32'(step),       32'(est));
        check({tag, "_done"}, 32'(instr_done), 32'(edone));
        check({tag, "_halt"}, 32'(halted),     32'(ehalt));
    endtask

    task automatic run_ins(input string tag, input logic [7:0] irv, input logic [1:0] fl,
                           input int n, input logic [15:0] e2, input logic [15:0] e3,
                           input logic [15:0] e4);
        logic [15:0] ecw;
        ir    = irv;
        flags = fl;
        for (int i = 0; i < n; i++) begin
            case (i)
                0:       ecw = W_F0;
                1:       ecw = W_F1;
                2:       ecw = e2;
                3:       ecw = e3;
                default: ecw = e4;
            endcase
            cyc($sformatf("%s_s%0d", tag, i), ecw, i, (i == n - 1), 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ir    = 8'h00;
        flags = 2'b00;
`ifdef CTRL_SINGLE_STEP_EN
        step_mode = 1'b0;
        step_req  = 1'b0;
`endif
        cyc("rst", 16'h0000, 0, 1'b0, 1'b0);
        cyc("rst2", 16'h0000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_ins("lda", 8'h1A, 2'b00, 4, W_IOMI, W_ROAI, 16'h0);
        run_ins("add", 8'h2F, 2'b00, 5, W_IOMI, W_ROBI, W_ADD4);
        run_ins("sub", 8'h35, 2'b00, 5, W_IOMI, W_ROBI, W_SUB4);
        run_ins("sta", 8'h4C, 2'b00, 4, W_IOMI, W_AORI, 16'h0);
        run_ins("ldi", 8'h57, 2'b00, 3, W_IOAI, 16'h0, 16'h0);
        run_ins("jmp", 8'h63, 2'b00, 3, W_IOJP, 16'h0, 16'h0);
        run_ins("jc_c1", 8'h73, 2'b10, 3, W_IOJP, 16'h0, 16'h0);
        run_ins("jc_c0", 8'h73, 2'b00, 3, W_IO, 16'h0, 16'h0);
        run_ins("jc_z", 8'h73, 2'b01, 3, W_IO, 16'h0, 16'h0);
        run_ins("jz_z1", 8'h84, 2'b01, 3, W_IOJP, 16'h0, 16'h0);
        run_ins("jz_c", 8'h84, 2'b10, 3, W_IO, 16'h0, 16'h0);
        run_ins("out", 8'hE1, 2'b00, 3, W_AOOI, 16'h0, 16'h0);
        run_ins("nop", 8'h00, 2'b00, 3, 16'h0, 16'h0, 16'h0);
        run_ins("undef", 8'h9B, 2'b00, 3, 16'h0, 16'h0, 16'h0);

        // Reset in the middle of ADD, just before step 3 would be emitted.
        ir = 8'h21;
        cyc("addr_s0", W_F0, 0, 1'b0, 1'b0);
        cyc("addr_s1", W_F1, 1, 1'b0, 1'b0);
        cyc("addr_s2", W_IOMI, 2, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc("addr_rst", 16'h0000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_ins("add_post", 8'h21, 2'b00, 5, W_IOMI, W_ROBI, W_ADD4);

`ifdef CTRL_SINGLE_STEP_EN
        begin
            logic [15:0] ss_cw [4];
            int          idx;
            int          hold_step;
            ss_cw[0] = W_F0;
            ss_cw[1] = W_F1;
            ss_cw[2] = W_IOMI;
            ss_cw[3] = W_ROAI;
            idx       = 0;
            hold_step = 4;
            ir        = 8'h1A;
            step_mode = 1'b1;
            for (int k = 0; k < 16; k++) begin
                step_req = ((k % 4) == 3);
                if (step_req) begin
                    cyc($sformatf("ss_k%0d", k), ss_cw[idx], idx, (idx == 3), 1'b0);
                    hold_step = idx;
                    idx++;
                end else begin
                    cyc($sformatf("ss_k%0d", k), 16'h0000, hold_step, 1'b0, 1'b0);
                end
            end
            step_req  = 1'b0;
            step_mode = 1'b0;
            run_ins("ss_free", 8'h57, 2'b00, 3, W_IOAI, 16'h0, 16'h0);
        end
`endif

        // Halt: frozen for ten edges, then only reset recovers.
        ir = 8'hF0;
        cyc("hlt_s0", W_F0, 0, 1'b0, 1'b0);
        cyc("hlt_s1", W_F1, 1, 1'b0, 1'b0);
        cyc("hlt_s2", W_HT, 2, 1'b1, 1'b1);
        ir = 8'h1A;
        for (int k = 0; k < 10; k++) begin
            cyc($sformatf("hlt_hold%0d", k), 16'h0000, 2, 1'b1, 1'b1);
        end
        rst_n = 1'b0;
        cyc("hlt_rst", 16'h0000, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_ins("lda_post", 8'h1A, 2'b00, 4, W_IOMI, W_ROAI, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
